mm_mult: RTL and testbench



---
 rtl/mm_mult.sv | 227 ++++++++++++++++++++++
 tb/tb_mm_mult.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm_mult.sv
// ---------------------------------------------------------------------------
// mm_mult -- single-word Montgomery multiplier
//
// Computes r = a * b * R^-1 mod n with R = 2^W. It consumes p = -n^-1 mod R
// from the upstream Montgomery setup stage (qualified by p_valid) and is
// iterated by the modexp controller for squarings and multiplies.
//
// One operation walks IDLE -> MAB -> MM -> MN -> FIN -> IDLE, one state per
// clock-enabled cycle:
//   MAB : t <= a*b                         (2W bits)
//   MM  : m <= t[W-1:0]*p mod 2^W          (W bits)
//   MN  : u <= t + m*n                     (2W+1 bits, carry kept)
//   FIN : s = u[2W:W]; r <= (s >= n) ? s-n : s; done pulse
//
// Optional feature macro: MM_MULT_CHECK_EN
//   defined   -> range check latched at accept (n even, a >= n, b >= n);
//                a failing request finishes with r = 0 and err = 1.
//   undefined -> no check logic, err tied low.
//
// Parameters
//   W        operand / modulus width in bits
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   ce       clock enable; low freezes every register, including done
//   start    request, sampled only in IDLE
//   a, b     Montgomery-domain operands (expected < n)
//   n        odd modulus
//   p        -n^-1 mod 2^W from the setup stage
//   p_valid  p is valid for the current n
//   busy     operation in flight
//   done     one-ce-cycle pulse; r valid from this cycle on
//   r        result, held until the next done
//   err      range-check flag, valid with done
// ---------------------------------------------------------------------------
module mm_mult #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    input  logic [W-1:0] p,
    input  logic         p_valid,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] r,
    output logic         err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAB  = 3'd1,
        ST_MM   = 3'd2,
        ST_MN   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic           accept_s;

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   n_r;
    logic [W-1:0]   p_r;
    logic [2*W-1:0] t_r;
    logic [W-1:0]   m_r;
    logic [2*W:0]   u_r;

    logic [W-1:0]   r_r;
    logic           busy_r;
    logic           done_r;

    logic [2*W-1:0] prod_ab_s;
    logic [W-1:0]   m_s;
    logic [2*W:0]   mn_s;
    logic [W:0]     s_s;
    logic [W:0]     n_ext_s;
    logic [W:0]     diff_s;
    logic           sub_s;
    logic [W-1:0]   res_s;
    logic [W-1:0]   res_final_s;

    // The low half of u is zero by construction and the borrow bit of the
    // subtract is implied by sub_s; neither feeds any logic.
    logic           unused_bits_s;

    // A request is taken only from IDLE and only once p matches the modulus.
    assign accept_s = (state_r == ST_IDLE) & start & p_valid;

    // Next-state logic: fixed four-step sequence once a request is accepted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_MAB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MAB:  state_s = ST_MM;
            ST_MM:   state_s = ST_MN;
            ST_MN:   state_s = ST_FIN;
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; ce low holds the FSM where it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (ce) begin
            state_r <= state_s;
        end
    end

    // Arithmetic for each step, zero-extended so no product bits are lost.
    always_comb begin
        prod_ab_s = {{W{1'b0}}, a_r} * {{W{1'b0}}, b_r};
        m_s       = t_r[W-1:0] * p_r;
        mn_s      = {1'b0, t_r} + ({{(W+1){1'b0}}, m_r} * {{(W+1){1'b0}}, n_r});
        // u[2W:W] is at most 2n-1, so one W+1-bit compare/subtract reduces it.
        s_s       = u_r[2*W:W];
        n_ext_s   = {1'b0, n_r};
        diff_s    = s_s - n_ext_s;
        sub_s     = (s_s >= n_ext_s);
        if (sub_s) begin
            res_s = diff_s[W-1:0];
        end else begin
            res_s = s_s[W-1:0];
        end
    end

    assign unused_bits_s = ^{u_r[W-1:0], diff_s[W]};

`ifdef MM_MULT_CHECK_EN
    logic chk_r;
    logic err_r;

    // Range check captured with the operands; err reported at FIN and
    // cleared by the next accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_r <= 1'b0;
            err_r <= 1'b0;
        end else if (ce) begin
            if (accept_s) begin
                chk_r <= ~n[0] | (a >= n) | (b >= n);
                err_r <= 1'b0;
            end else if (state_r == ST_FIN) begin
                err_r <= chk_r;
            end
        end
    end

    // A failed check forces a zero result.
    always_comb begin
        if (chk_r) begin
            res_final_s = {W{1'b0}};
        end else begin
            res_final_s = res_s;
        end
    end

    assign err = err_r;
`else
    // Without the range check the result passes straight through.
    always_comb begin
        res_final_s = res_s;
    end

    assign err = 1'b0;
`endif

    // Operand capture and per-step datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {W{1'b0}};
            b_r <= {W{1'b0}};
            n_r <= {W{1'b0}};
            p_r <= {W{1'b0}};
            t_r <= {(2*W){1'b0}};
            m_r <= {W{1'b0}};
            u_r <= {(2*W+1){1'b0}};
            r_r <= {W{1'b0}};
        end else if (ce) begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r <= a;
                        b_r <= b;
                        n_r <= n;
                        p_r <= p;
                    end
                end
                ST_MAB:  t_r <= prod_ab_s;
                ST_MM:   m_r <= m_s;
                ST_MN:   u_r <= mn_s;
                ST_FIN:  r_r <= res_final_s;
                default: r_r <= r_r;
            endcase
        end
    end

    // Status outputs; done lasts one ce cycle and stretches over ce-low gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (ce) begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_r == ST_FIN);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign r    = r_r;

endmodule

// File: tb/tb_mm_mult.sv
// ---------------------------------------------------------------------------
// tb_mm_mult -- self-checking bench for mm_mult (W = 16)
//
// Directed cases for the documented corner behaviour plus a random sweep
// compared against a plain-arithmetic Montgomery reference
// (a*b*inverse(2^16) mod n, with p derived from n by the bench).
// ---------------------------------------------------------------------------
module tb_mm_mult;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         ce;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] p;
    logic         p_valid;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         err;

    int total;
    int bad;

    mm_mult #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .start   (start),
        .a       (a),
        .b       (b),
        .n       (n),
        .p       (p),
        .p_valid (p_valid),
        .busy    (busy),
        .done    (done),
        .r       (r),
        .err     (err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Modular inverse of x mod m by the extended Euclidean algorithm.
    function automatic longint modinv(input longint x, input longint m);
        longint t0, t1, r0, r1, q, tmp;
        t0 = 0; t1 = 1; r0 = m; r1 = x % m;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
        end
        if (t0 < 0) t0 = t0 + m;
        return t0;
    endfunction

    // Reference result a*b*R^-1 mod n, R = 2^16.
    function automatic longint ref_mont(input longint ra, input longint rb, input longint rn);
        longint rinv;
        rinv = modinv(65536 % rn, rn);
        return (((ra * rb) % rn) * rinv) % rn;
    endfunction

    // p = -n^-1 mod 2^16 via Newton iteration on the 2-adic inverse.
    function automatic longint ref_p(input longint rn);
        longint inv;
        inv = rn;
        for (int k = 0; k < 5; k++) begin
            inv = (inv * (2 - rn * inv)) & 64'hFFFF;
        end
        return (65536 - inv) & 64'hFFFF;
    endfunction

    // Present a request at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] in_, input logic [W-1:0] ip);
        a = ia; b = ib; n = in_; p = ip;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Wait for done, counting clock-enabled edges; optional random ce stalls.
    task automatic wait_done(input bit rand_ce, output int cyc);
        int guard;
        cyc = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            if (rand_ce) ce = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (ce) cyc++;
            guard++;
            @(negedge clk);
        end
        ce = 1'b1;
        if (guard >= 100) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        logic [W-1:0] rn, ra, rb, rp;
        longint exp_r;

        total = 0; bad = 0;
        clk = 1'b0; rst = 1'b1; ce = 1'b1; start = 1'b0;
        a = '0; b = '0; n = '0; p = '0; p_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_r",    {48'd0, r},    64'd0);
        check_val("rst_err",  {63'd0, err},  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic product, 4-cycle latency.
        issue(16'd5, 16'd7, 16'h0011, 16'h0F0F);
        wait_done(1'b0, cyc);
        check_val("t1_lat", cyc, 64'd4);
        check_val("t1_r",   {48'd0, r},   64'd1);
        check_val("t1_err", {63'd0, err}, 64'd0);
        check_val("t1_busy_at_done", {63'd0, busy}, 64'd0);
        @(posedge clk); @(negedge clk);
        check_val("t1_done_one_cycle", {63'd0, done}, 64'd0);

        // 2: largest modulus, final subtract taken.
        issue(16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h0001);
        wait_done(1'b0, cyc);
        check_val("t2_r", {48'd0, r}, 64'd1);

        // 3: zero operand, then back-to-back start in the done cycle.
        issue(16'd0, 16'd9, 16'h0011, 16'h0F0F);
        wait_done(1'b0, cyc);
        check_val("t3a_r", {48'd0, r}, 64'd0);
        issue(16'h0010, 16'h0010, 16'h0011, 16'h0F0F);
        check_val("t3_done_dropped", {63'd0, done}, 64'd0);
        wait_done(1'b0, cyc);
        check_val("t3b_lat", cyc, 64'd4);
        check_val("t3b_r", {48'd0, r}, 64'd1);

        // 4: ce stall in MN and across done.
        issue(16'd5, 16'd7, 16'h0011, 16'h0F0F);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check_val("t4_stall_busy", {63'd0, busy}, 64'd1);
            check_val("t4_stall_done", {63'd0, done}, 64'd0);
        end
        ce = 1'b1;
        wait_done(1'b0, cyc);
        check_val("t4_remaining_lat", cyc, 64'd2);
        check_val("t4_r", {48'd0, r}, 64'd1);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check_val("t4_done_held", {63'd0, done}, 64'd1);
            check_val("t4_r_held", {48'd0, r}, 64'd1);
        end
        ce = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("t4_done_clear", {63'd0, done}, 64'd0);

        // 5: reset in MM aborts; start without p_valid is ignored.
        issue(16'd3, 16'd4, 16'h0011, 16'h0F0F);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check_val("t5_busy", {63'd0, busy}, 64'd0);
        check_val("t5_done", {63'd0, done}, 64'd0);
        check_val("t5_r",    {48'd0, r},    64'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check_val("t5_no_done", {63'd0, seen}, 64'd0);
        a = 16'd1; b = 16'd1; n = 16'h0011; p = 16'h0F0F;
        p_valid = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("t5_pvalid_ignored", {63'd0, busy}, 64'd0);
        start = 1'b0; p_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("t5_still_idle", {63'd0, busy}, 64'd0);

        // 6: even modulus.
        issue(16'd1, 16'd1, 16'h0010, 16'h0000);
        wait_done(1'b0, cyc);
        check_val("t6_lat", cyc, 64'd4);
`ifdef MM_MULT_CHECK_EN
        check_val("t6_err", {63'd0, err}, 64'd1);
        check_val("t6_r",   {48'd0, r},   64'd0);
`else
        check_val("t6_err", {63'd0, err}, 64'd0);
`endif

        // Random sweep against the reference model, with random ce stalls.
        for (int i = 0; i < 40; i++) begin
            rn = 16'(($urandom_range(1, 32767) * 2) + 1);
            ra = 16'($urandom_range(0, int'(rn) - 1));
            rb = 16'($urandom_range(0, int'(rn) - 1));
            rp = 16'(ref_p(longint'(rn)));
            exp_r = ref_mont(longint'(ra), longint'(rb), longint'(rn));
            issue(ra, rb, rn, rp);
            wait_done(i[0], cyc);
            check_val("rnd_lat", cyc, 64'd4);
            check_val("rnd_r", {48'd0, r}, 64'(exp_r));
            check_val("rnd_err", {63'd0, err}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
